// File: rtl/mem_bridge.sv
// Data-side bridge from the multicycle CPU to a word-wide synchronous RAM (loads, stores, sub-word RMW).
// Latency: misaligned 1 cycle, word store 2, load RD_LAT+2, sub-word store RD_LAT+3 (req cycle = 0).
// Backpressure: one access at a time; req is ignored until the cycle after the ready pulse.
// Ports: clk/rst (sync, active-high); CPU side req/we/addr/wdata/size/sign -> rdata/ready/addr_err;
//        RAM side ram_en/ram_we/ram_addr/ram_wdata -> ram_rdata (valid RD_LAT cycles after the ram_en edge).
module mem_bridge #(
   parameter int ADDR_W = 11,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic [1:0]        size,
   input  logic              sign,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              addr_err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ERR, S_WRITE, S_ISSUE, S_WAIT, S_MERGE, S_DONE
   } state_t;

   state_t state, state_nxt;

   // Latched request
   logic              we_q;
   logic [1:0]        lane_q;
   logic [ADDR_W-1:0] word_q;
   logic [31:0]       wdata_q;
   logic [1:0]        size_q;
   logic              sign_q;

   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       raw_q;
   logic [31:0]       rdata_q;

   logic              misaligned;
   logic              rd_last;
   logic [4:0]        lane_sh;
   logic [31:0]       rd_shift;
   logic [31:0]       load_ext;
   logic [31:0]       lane_mask;
   logic [31:0]       lane_data;
   logic [31:0]       merged;

   // Address bits above the RAM word index alias onto the same word.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[31:ADDR_W+2];

   assign misaligned = (size == 2'b11) ||
                       (size == 2'b00 && addr[1:0] != 2'b00) ||
                       (size == 2'b01 && addr[0]);

   // Last WAIT cycle: ram_rdata is valid now.
   assign rd_last = (cnt_q == CNT_W'(RD_LAT - 1));

   // Lane extraction and merge. An aligned half has lane_q[0]=0, so the byte
   // shift of lane*8 also selects the correct half.
   always_comb begin
      lane_sh  = {lane_q, 3'b000};
      rd_shift = ram_rdata >> lane_sh;
      case (size_q)
         2'b10:   load_ext = {{24{sign_q & rd_shift[7]}},  rd_shift[7:0]};
         2'b01:   load_ext = {{16{sign_q & rd_shift[15]}}, rd_shift[15:0]};
         default: load_ext = ram_rdata;
      endcase
      lane_mask = (size_q == 2'b10) ? 32'h0000_00FF : 32'h0000_FFFF;
      lane_data = (size_q == 2'b10) ? {24'h0, wdata_q[7:0]} : {16'h0, wdata_q[15:0]};
      merged    = (raw_q & ~(lane_mask << lane_sh)) | (lane_data << lane_sh);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req) begin
               if (misaligned)                 state_nxt = S_ERR;
               else if (we && size == 2'b00)   state_nxt = S_WRITE;
               else                            state_nxt = S_ISSUE;
            end
         end
         S_ERR:   state_nxt = S_IDLE;
         S_WRITE: state_nxt = S_DONE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (rd_last) state_nxt = we_q ? S_MERGE : S_DONE;
         S_MERGE: state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      ready     = (state == S_ERR) || (state == S_DONE);
      addr_err  = (state == S_ERR);
      ram_en    = (state == S_WRITE) || (state == S_ISSUE) || (state == S_MERGE);
      ram_we    = (state == S_WRITE) || (state == S_MERGE);
      ram_wdata = 32'h0;
      if (state == S_WRITE)      ram_wdata = wdata_q;
      else if (state == S_MERGE) ram_wdata = merged;
   end

   assign ram_addr = word_q;
   assign rdata    = rdata_q;

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         lane_q  <= 2'b00;
         word_q  <= '0;
         wdata_q <= 32'h0;
         size_q  <= 2'b00;
         sign_q  <= 1'b0;
         cnt_q   <= '0;
         raw_q   <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         if (state == S_IDLE && req) begin
            we_q    <= we;
            lane_q  <= addr[1:0];
            word_q  <= addr[ADDR_W+1:2];
            wdata_q <= wdata;
            size_q  <= size;
            sign_q  <= sign;
         end
         if (state == S_ISSUE)     cnt_q <= '0;
         else if (state == S_WAIT) cnt_q <= cnt_q + 1'b1;
         if (state == S_WAIT && rd_last) begin
            if (we_q) raw_q   <= ram_rdata;
            else      rdata_q <= load_ext;
         end
      end
   end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: instance a (RD_LAT=1) and instance b (RD_LAT=3),
// each backed by its own behavioural synchronous RAM with the matching read latency.
module tb_mem_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_a = 1'b0, req_b = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic [1:0]  size = 2'b00;
   logic        sign = 1'b0;

   logic [31:0] rdata_a, rdata_b;
   logic        ready_a, ready_b, addr_err_a, addr_err_b;
   logic        ram_en_a, ram_en_b, ram_we_a, ram_we_b;
   logic [10:0] ram_addr_a, ram_addr_b;
   logic [31:0] ram_wdata_a, ram_wdata_b;
   logic [31:0] ram_rdata_a, ram_rdata_b;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_bridge #(.ADDR_W(11), .RD_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
      .size(size), .sign(sign), .rdata(rdata_a), .ready(ready_a), .addr_err(addr_err_a),
      .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a),
      .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a)
   );

   mem_bridge #(.ADDR_W(11), .RD_LAT(3)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
      .size(size), .sign(sign), .rdata(rdata_b), .ready(ready_b), .addr_err(addr_err_b),
      .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b),
      .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b)
   );

   // RAM models; read data is poisoned outside its valid cycle.
   logic [31:0] mem_a [0:2047] = '{default: 32'h0};
   logic [31:0] mem_b [0:2047] = '{default: 32'h0};
   logic [31:0] pipe_b [0:2];

   always @(posedge clk) begin
      ram_rdata_a <= (ram_en_a && !ram_we_a) ? mem_a[ram_addr_a] : 32'hDEADBEEF;
      if (ram_en_a && ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
   end

   always @(posedge clk) begin
      pipe_b[0] <= (ram_en_b && !ram_we_b) ? mem_b[ram_addr_b] : 32'hDEADBEEF;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
      if (ram_en_b && ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
   end
   assign ram_rdata_b = pipe_b[2];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Issue one request in the current cycle (called at posedge+1) and follow it
   // to the ready pulse. Returns ready latency (-1 on timeout), addr_err, rdata
   // and the number of RAM write / read strobes seen. Returns at posedge+1 of
   // the cycle after ready.
   task automatic do_op(input bit use_b, input bit hold, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic sg,
                        output int lat, output logic err, output logic [31:0] rd,
                        output int n_wr, output int n_rd);
      we = w; addr = a; wdata = d; size = sz; sign = sg;
      if (use_b) req_b = 1'b1; else req_a = 1'b1;
      lat = -1; err = 1'b0; rd = 32'h0; n_wr = 0; n_rd = 0;
      @(posedge clk); #1;
      if (!hold) begin req_a = 1'b0; req_b = 1'b0; end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (use_b ? ram_en_b : ram_en_a) begin
            if (use_b ? ram_we_b : ram_we_a) n_wr++;
            else n_rd++;
         end
         if (use_b ? ready_b : ready_a) begin
            lat = k;
            err = use_b ? addr_err_b : addr_err_a;
            rd  = use_b ? rdata_b : rdata_a;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      req_a = 1'b0; req_b = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({ready_a, addr_err_a, ram_en_a, ram_we_a} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {ready_a, addr_err_a, ram_en_a, ram_we_a});
      end
      n_vec++;
      if (rdata_a !== 32'h0 || ram_addr_a !== 11'h0 || ram_wdata_a !== 32'h0) begin
         n_bad++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want all 0", rdata_a, ram_addr_a, ram_wdata_a);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_word();
      int lat, nw, nr; logic err; logic [31:0] rd;
      do_op(0, 0, 1'b1, 32'h4, 32'h11223344, 2'b00, 1'b0, lat, err, rd, nw, nr);
      n_vec++;
      if (lat !== 2 || err !== 1'b0 || nw !== 1 || nr !== 0) begin
         n_bad++; $display("FAIL sw_timing: got lat=%0d err=%b wr=%0d rd=%0d want 2 0 1 0", lat, err, nw, nr);
      end
      n_vec++;
      if (mem_a[1] !== 32'h11223344) begin
         n_bad++; $display("FAIL sw_mem: got %h want 11223344", mem_a[1]);
      end
      do_op(0, 0, 1'b0, 32'h4, 32'h0, 2'b00, 1'b0, lat, err, rd, nw, nr);
      n_vec++;
      if (lat !== 3 || err !== 1'b0 || rd !== 32'h11223344 || nr !== 1 || nw !== 0) begin
         n_bad++; $display("FAIL lw: got lat=%0d err=%b rdata=%h rd=%0d wr=%0d want 3 0 11223344 1 0", lat, err, rd, nr, nw);
      end
   endtask

   task automatic test_byte();
      int lat, nw, nr; logic err; logic [31:0] rd;
      do_op(0, 0, 1'b1, 32'h5, 32'hFFFFFFAB, 2'b10, 1'b0, lat, err, rd, nw, nr);
      n_vec++;
      if (lat !== 4 || err !== 1'b0 || nw !== 1 || nr !== 1) begin
         n_bad++; $display("FAIL sb_timing: got lat=%0d err=%b wr=%0d rd=%0d want 4 0 1 1", lat, err, nw, nr);
      end
      n_vec++;
      if (mem_a[1] !== 32'h1122AB44) begin
         n_bad++; $display("FAIL sb_mem: got %h want 1122ab44", mem_a[1]);
      end
      do_op(0, 0, 1'b0, 32'h5, 32'h0, 2'b10, 1'b1, lat, err, rd, nw, nr);
      n_vec++;
      if (lat !== 3 || rd !== 32'hFFFFFFAB) begin
         n_bad++; $display("FAIL lb: got lat=%0d rdata=%h want 3 ffffffab", lat, rd);
      end
      do_op(0, 0, 1'b0, 32'h5, 32'h0, 2'b10, 1'b0, lat, err, rd, nw, nr);
      n_vec++;
      if (rd !== 32'h000000AB) begin
         n_bad++; $display("FAIL lbu: got %h want 000000ab", rd);
      end
   endtask

   task automatic test_half();
      int lat, nw, nr; logic err; logic [31:0] rd;
      do_op(0, 0, 1'b1, 32'h6, 32'h12348001, 2'b01, 1'b0, lat, err, rd, nw, nr);
      n_vec++;
      if (lat !== 4 || nw !== 1 || mem_a[1] !== 32'h8001AB44) begin
         n_bad++; $display("FAIL sh: got lat=%0d wr=%0d mem=%h want 4 1 8001ab44", lat, nw, mem_a[1]);
      end
      do_op(0, 0, 1'b0, 32'h6, 32'h0, 2'b01, 1'b1, lat, err, rd, nw, nr);
      n_vec++;
      if (rd !== 32'hFFFF8001) begin
         n_bad++; $display("FAIL lh_hi: got %h want ffff8001", rd);
      end
      do_op(0, 0, 1'b0, 32'h6, 32'h0, 2'b01, 1'b0, lat, err, rd, nw, nr);
      n_vec++;
      if (rd !== 32'h00008001) begin
         n_bad++; $display("FAIL lhu_hi: got %h want 00008001", rd);
      end
      do_op(0, 0, 1'b0, 32'h4, 32'h0, 2'b01, 1'b1, lat, err, rd, nw, nr);
      n_vec++;
      if (rd !== 32'hFFFFAB44) begin
         n_bad++; $display("FAIL lh_lo: got %h want ffffab44", rd);
      end
   endtask

   task automatic test_misaligned();
      int lat, nw, nr; logic err; logic [31:0] rd;
      logic [31:0] a_tab [0:2] = '{32'h2, 32'h3, 32'h0};
      logic        w_tab [0:2] = '{1'b0, 1'b1, 1'b0};
      logic [1:0]  s_tab [0:2] = '{2'b00, 2'b01, 2'b11};
      for (int i = 0; i < 3; i++) begin
         do_op(0, 0, w_tab[i], a_tab[i], 32'h5555AAAA, s_tab[i], 1'b1, lat, err, rd, nw, nr);
         n_vec++;
         if (lat !== 1 || err !== 1'b1 || nw !== 0 || nr !== 0 || rd !== 32'hFFFFAB44) begin
            n_bad++;
            $display("FAIL misaligned_%0d: got lat=%0d err=%b wr=%0d rd=%0d rdata=%h want 1 1 0 0 ffffab44",
                     i, lat, err, nw, nr, rd);
         end
      end
      n_vec++;
      if (mem_a[0] !== 32'h0) begin
         n_bad++; $display("FAIL misaligned_mem: got %h want 00000000", mem_a[0]);
      end
   endtask

   task automatic test_wrap();
      int lat, nw, nr; logic err; logic [31:0] rd;
      do_op(0, 0, 1'b0, 32'h2004, 32'h0, 2'b00, 1'b0, lat, err, rd, nw, nr);
      n_vec++;
      if (rd !== 32'h8001AB44) begin
         n_bad++; $display("FAIL wrap_lw: got %h want 8001ab44", rd);
      end
      do_op(0, 0, 1'b0, 32'h7, 32'h0, 2'b10, 1'b0, lat, err, rd, nw, nr);
      n_vec++;
      if (rd !== 32'h00000080) begin
         n_bad++; $display("FAIL lbu_lane3: got %h want 00000080", rd);
      end
   endtask

   task automatic test_reset_mid();
      int lat, nw, nr, seen_rdy, seen_en; logic err; logic [31:0] rd;
      we = 1'b1; addr = 32'h5; wdata = 32'h000000CD; size = 2'b10; sign = 1'b0;
      req_a = 1'b1;
      @(posedge clk); #1;   // ISSUE
      req_a = 1'b0;
      @(posedge clk); #1;   // WAIT
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({ready_a, addr_err_a, ram_en_a, ram_we_a} !== 4'b0000 || rdata_a !== 32'h0 ||
          ram_addr_a !== 11'h0 || ram_wdata_a !== 32'h0) begin
         n_bad++;
         $display("FAIL rst_mid_outputs: got ctrl=%b rdata=%h addr=%h wdata=%h want all 0",
                  {ready_a, addr_err_a, ram_en_a, ram_we_a}, rdata_a, ram_addr_a, ram_wdata_a);
      end
      seen_rdy = 0; seen_en = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (ready_a) seen_rdy++;
         if (ram_en_a) seen_en++;
      end
      @(posedge clk); #1;
      n_vec++;
      if (seen_rdy !== 0 || seen_en !== 0 || mem_a[1] !== 32'h8001AB44) begin
         n_bad++; $display("FAIL rst_mid_quiet: got rdy=%0d en=%0d mem=%h want 0 0 8001ab44", seen_rdy, seen_en, mem_a[1]);
      end
      do_op(0, 0, 1'b0, 32'h5, 32'h0, 2'b10, 1'b0, lat, err, rd, nw, nr);
      n_vec++;
      if (lat !== 3 || rd !== 32'h000000AB) begin
         n_bad++; $display("FAIL rst_mid_recover: got lat=%0d rdata=%h want 3 000000ab", lat, rd);
      end
   endtask

   task automatic test_back_to_back();
      int lat, nw, nr, seen_en; logic err; logic [31:0] rd;
      do_op(1, 1, 1'b1, 32'h10, 32'hCAFEF00D, 2'b00, 1'b0, lat, err, rd, nw, nr);
      n_vec++;
      if (lat !== 2 || nw !== 1 || mem_b[4] !== 32'hCAFEF00D) begin
         n_bad++; $display("FAIL b_sw: got lat=%0d wr=%0d mem=%h want 2 1 cafef00d", lat, nw, mem_b[4]);
      end
      do_op(1, 1, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, lat, err, rd, nw, nr);
      n_vec++;
      if (lat !== 5 || rd !== 32'hCAFEF00D || nr !== 1 || nw !== 0 || err !== 1'b0) begin
         n_bad++; $display("FAIL b_lw_lat3: got lat=%0d rdata=%h rd=%0d wr=%0d err=%b want 5 cafef00d 1 0 0", lat, rd, nr, nw, err);
      end
      do_op(1, 1, 1'b1, 32'h12, 32'h0000BEEF, 2'b01, 1'b0, lat, err, rd, nw, nr);
      n_vec++;
      if (lat !== 6 || nw !== 1 || nr !== 1 || mem_b[4] !== 32'hBEEFF00D) begin
         n_bad++; $display("FAIL b_sh_lat3: got lat=%0d wr=%0d rd=%0d mem=%h want 6 1 1 beeff00d", lat, nw, nr, mem_b[4]);
      end
      seen_en = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (ram_en_b) seen_en++;
      end
      @(posedge clk); #1;
      n_vec++;
      if (seen_en !== 0) begin
         n_bad++; $display("FAIL b_idle_after: got en=%0d want 0", seen_en);
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_misaligned();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
